// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM encoding, default bit period, frame width.
// The default bit period is shared with the transmitter so both ends agree on baud timing.
package uart_pkg;

    localparam int DEFAULT_CLKS_PER_BIT = 16;
    localparam int DATA_BITS            = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } uart_rx_state_t;

endpackage

// File: rtl/uart_receiver_if.sv
// Receiver-to-consumer byte handshake with status flags.
// The master modport is the receiver side; the slave modport is the consumer side.
interface uart_receiver_if;
    import uart_pkg::*;

    logic [DATA_BITS-1:0] data_out;
    logic                 rx_valid;
    logic                 rx_ack;
    logic                 rx_ongoing;
    logic                 rx_done;
    logic                 rx_frame_err;
    logic                 rx_overrun;

    modport master (
        output data_out, rx_valid, rx_ongoing, rx_done, rx_frame_err, rx_overrun,
        input  rx_ack
    );

    modport slave (
        input  data_out, rx_valid, rx_ongoing, rx_done, rx_frame_err, rx_overrun,
        output rx_ack
    );

endinterface

// File: rtl/uart_sync_2ff.sv
// Two-flop synchroniser for the asynchronous serial line; resets to the idle-high level.
// Latency: 2 clk. Backpressure: none.
module uart_sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_meta <= 1'b1;
            r_q    <= 1'b1;
        end else begin
            r_meta <= i_d;
            r_q    <= r_meta;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: mid-bit start validation, centre sampling, valid/ack byte output.
// Latency: rx_done one cycle after the stop-bit sample (T0+154 at 16 clk/bit).
// Backpressure: a good byte arriving while rx_valid is pending is dropped and flags rx_overrun.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             data_in_rx,
    uart_receiver_if.master  rx_if
);

    localparam int HALF_BIT = CLKS_PER_BIT / 2;
    localparam int CNT_W    = $clog2(CLKS_PER_BIT);
    localparam int IDX_W    = $clog2(DATA_BITS);

    typedef logic [CNT_W-1:0]     cnt_t;
    typedef logic [IDX_W-1:0]     idx_t;
    typedef logic [DATA_BITS-1:0] byte_t;

    localparam cnt_t HALF_LAST = cnt_t'(HALF_BIT - 1);
    localparam cnt_t BIT_LAST  = cnt_t'(CLKS_PER_BIT - 1);
    localparam idx_t IDX_LAST  = idx_t'(DATA_BITS - 1);

    logic           w_sync_rx;
    uart_rx_state_t r_state;
    uart_rx_state_t w_state_nxt;
    cnt_t           r_cnt;
    cnt_t           w_cnt_nxt;
    idx_t           r_bit_idx;
    idx_t           w_bit_idx_nxt;
    byte_t          r_shift;
    byte_t          w_shift_nxt;
    logic           w_good;
    logic           w_bad;

    byte_t          r_data;
    logic           r_valid;
    logic           r_done;
    logic           r_frame_err;
    logic           r_overrun;

    uart_sync_2ff u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (data_in_rx),
        .o_q   (w_sync_rx)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_bit_idx <= w_bit_idx_nxt;
            r_shift   <= w_shift_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_bit_idx_nxt = r_bit_idx;
        w_shift_nxt   = r_shift;
        w_good        = 1'b0;
        w_bad         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_sync_rx) begin
                    w_state_nxt = ST_START;
                    w_cnt_nxt   = '0;
                end
            end
            ST_START: begin
                if (r_cnt == HALF_LAST) begin
                    w_cnt_nxt = '0;
                    if (!w_sync_rx) begin
                        w_state_nxt   = ST_DATA;
                        w_bit_idx_nxt = '0;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + cnt_t'(1);
                end
            end
            ST_DATA: begin
                if (r_cnt == BIT_LAST) begin
                    w_cnt_nxt              = '0;
                    w_shift_nxt[r_bit_idx] = w_sync_rx;
                    w_bit_idx_nxt          = r_bit_idx + idx_t'(1);
                    if (r_bit_idx == IDX_LAST) begin
                        w_state_nxt = ST_STOP;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + cnt_t'(1);
                end
            end
            ST_STOP: begin
                if (r_cnt == BIT_LAST) begin
                    w_cnt_nxt = '0;
                    if (w_sync_rx) begin
                        w_good      = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_bad       = 1'b1;
                        w_state_nxt = ST_BREAK;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + cnt_t'(1);
                end
            end
            // Wait out a held-low line so it cannot be mistaken for a new start bit.
            ST_BREAK: begin
                if (w_sync_rx) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_done      <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_done      <= w_good;
            r_frame_err <= w_bad;
            if (w_good) begin
                // An ack landing on the completion edge frees the slot for the new byte.
                if (!r_valid || rx_if.rx_ack) begin
                    r_data    <= r_shift;
                    r_valid   <= 1'b1;
                    r_overrun <= 1'b0;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_valid && rx_if.rx_ack) begin
                r_valid   <= 1'b0;
                r_overrun <= 1'b0;
            end
        end
    end

    assign rx_if.data_out     = r_data;
    assign rx_if.rx_valid     = r_valid;
    assign rx_if.rx_done      = r_done;
    assign rx_if.rx_frame_err = r_frame_err;
    assign rx_if.rx_overrun   = r_overrun;
    assign rx_if.rx_ongoing   = (r_state == ST_START) || (r_state == ST_DATA) || (r_state == ST_STOP);

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: a transmitter model drives 8N1 frames and a
// scoreboard holds the data_out value expected at each rx_done pulse.
module tb_uart_receiver;
    import uart_pkg::*;

    localparam int CPB  = 16;
    localparam int HALF = CPB / 2;
    localparam int LAT  = 154;

    logic clk        = 1'b0;
    logic rst_n      = 1'b0;
    logic data_in_rx = 1'b1;

    int checks        = 0;
    int failures      = 0;
    int cyc           = 0;
    int done_count    = 0;
    int err_count     = 0;
    int last_done_cyc = -1;
    int t_start       = 0;

    logic       prev_done = 1'b0;
    logic       prev_err  = 1'b0;
    logic [7:0] exp_q[$];

    uart_receiver_if rx_if();

    uart_receiver #(.CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .data_in_rx (data_in_rx),
        .rx_if      (rx_if)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor: every rx_done pops one expected data_out value.
    always @(negedge clk) begin
        if (rx_if.rx_done) begin
            logic [7:0] exp_b;
            done_count    = done_count + 1;
            last_done_cyc = cyc;
            checks = checks + 1;
            if (exp_q.size() == 0) begin
                failures = failures + 1;
                $display("FAIL sb_unexpected_done: data_out=%h with empty scoreboard", rx_if.data_out);
            end else begin
                exp_b = exp_q.pop_front();
                if (rx_if.data_out !== exp_b) begin
                    failures = failures + 1;
                    $display("FAIL sb_data_out: got %h expected %h", rx_if.data_out, exp_b);
                end
            end
            checks = checks + 1;
            if (prev_done) begin
                failures = failures + 1;
                $display("FAIL done_pulse_width: rx_done high %0d consecutive cycles, expected 1", 2);
            end
        end
        if (rx_if.rx_frame_err) begin
            err_count = err_count + 1;
            checks = checks + 1;
            if (prev_err) begin
                failures = failures + 1;
                $display("FAIL err_pulse_width: rx_frame_err high %0d consecutive cycles, expected 1", 2);
            end
        end
        prev_done = rx_if.rx_done;
        prev_err  = rx_if.rx_frame_err;
    end

    // Called at a negedge; returns at the negedge ending the stop bit.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic ack_at_stop);
        t_start = cyc + 1;
        data_in_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            data_in_rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        data_in_rx = stop_bit;
        for (int k = 0; k < CPB; k++) begin
            if (ack_at_stop) rx_if.rx_ack = (k == HALF + 2);
            @(negedge clk);
        end
    endtask

    task automatic idle(input int n);
        data_in_rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_ack();
        rx_if.rx_ack = 1'b1;
        @(negedge clk);
        rx_if.rx_ack = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        rx_if.rx_ack = 1'b0;
        data_in_rx = 1'b1;
        repeat (3) @(negedge clk);
        checks = checks + 1;
        if ({rx_if.data_out, rx_if.rx_valid, rx_if.rx_ongoing, rx_if.rx_done,
             rx_if.rx_frame_err, rx_if.rx_overrun} !== 13'd0) begin
            failures = failures + 1;
            $display("FAIL reset_outputs: data_out=%h valid=%b ongoing=%b done=%b err=%b ovr=%b, expected all 0",
                     rx_if.data_out, rx_if.rx_valid, rx_if.rx_ongoing, rx_if.rx_done,
                     rx_if.rx_frame_err, rx_if.rx_overrun);
        end
        rst_n = 1'b1;
        idle(4);
    endtask

    task automatic test_loopback();
        int d0, e0, t0;
        d0 = done_count;
        e0 = err_count;
        exp_q.push_back(8'hB7);
        send_frame(8'b10110111, 1'b1, 1'b0);
        t0 = t_start;
        idle(4);
        checks = checks + 1;
        if (rx_if.data_out !== 8'hB7) begin
            failures = failures + 1;
            $display("FAIL loop_data: got %h expected %h", rx_if.data_out, 8'hB7);
        end
        checks = checks + 1;
        if (rx_if.rx_valid !== 1'b1) begin
            failures = failures + 1;
            $display("FAIL loop_valid: got %b expected 1", rx_if.rx_valid);
        end
        checks = checks + 1;
        if (last_done_cyc !== t0 + LAT) begin
            failures = failures + 1;
            $display("FAIL loop_latency: done at cycle %0d expected %0d", last_done_cyc, t0 + LAT);
        end
        checks = checks + 1;
        if (done_count - d0 !== 1 || err_count !== e0) begin
            failures = failures + 1;
            $display("FAIL loop_pulses: done=%0d err=%0d expected done=1 err=0", done_count - d0, err_count - e0);
        end
        pulse_ack();
        checks = checks + 1;
        if (rx_if.rx_valid !== 1'b0) begin
            failures = failures + 1;
            $display("FAIL loop_ack_clear: valid=%b expected 0", rx_if.rx_valid);
        end
        idle(4);
    endtask

    task automatic test_glitch();
        int d0, e0, ongoing_cycles;
        d0 = done_count;
        e0 = err_count;
        ongoing_cycles = 0;
        data_in_rx = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (i == 3) data_in_rx = 1'b1;
            if (rx_if.rx_ongoing === 1'b1) ongoing_cycles = ongoing_cycles + 1;
        end
        checks = checks + 1;
        if (ongoing_cycles !== HALF) begin
            failures = failures + 1;
            $display("FAIL glitch_ongoing: high %0d cycles expected %0d", ongoing_cycles, HALF);
        end
        checks = checks + 1;
        if (done_count !== d0 || err_count !== e0 || rx_if.rx_valid !== 1'b0) begin
            failures = failures + 1;
            $display("FAIL glitch_no_output: done=%0d err=%0d valid=%b expected 0 0 0",
                     done_count - d0, err_count - e0, rx_if.rx_valid);
        end
    endtask

    task automatic test_frame_err();
        int d0, e0, ongoing_cycles;
        d0 = done_count;
        e0 = err_count;
        ongoing_cycles = 0;
        send_frame(8'h55, 1'b0, 1'b0);
        for (int i = 0; i < 40 + 2 * CPB; i++) begin
            if (i == 40) data_in_rx = 1'b1;
            @(negedge clk);
            if (rx_if.rx_ongoing === 1'b1) ongoing_cycles = ongoing_cycles + 1;
        end
        checks = checks + 1;
        if (err_count - e0 !== 1) begin
            failures = failures + 1;
            $display("FAIL ferr_count: frame_err pulses %0d expected 1", err_count - e0);
        end
        checks = checks + 1;
        if (ongoing_cycles !== 0) begin
            failures = failures + 1;
            $display("FAIL ferr_no_restart: ongoing %0d cycles during break expected 0", ongoing_cycles);
        end
        checks = checks + 1;
        if (rx_if.rx_valid !== 1'b0 || done_count !== d0) begin
            failures = failures + 1;
            $display("FAIL ferr_discard: valid=%b done=%0d expected 0 0", rx_if.rx_valid, done_count - d0);
        end
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, 1'b1, 1'b0);
        idle(4);
        checks = checks + 1;
        if (rx_if.data_out !== 8'h3C || rx_if.rx_valid !== 1'b1 || err_count - e0 !== 1) begin
            failures = failures + 1;
            $display("FAIL ferr_recover: data_out=%h valid=%b errs=%0d expected 3c 1 1",
                     rx_if.data_out, rx_if.rx_valid, err_count - e0);
        end
        pulse_ack();
        idle(4);
    endtask

    task automatic test_overrun();
        int d0;
        d0 = done_count;
        exp_q.push_back(8'h12);
        send_frame(8'h12, 1'b1, 1'b0);
        exp_q.push_back(8'h12);
        send_frame(8'h34, 1'b1, 1'b0);
        idle(4);
        checks = checks + 1;
        if (rx_if.data_out !== 8'h12 || rx_if.rx_overrun !== 1'b1) begin
            failures = failures + 1;
            $display("FAIL ovr_state: data_out=%h overrun=%b expected 12 1", rx_if.data_out, rx_if.rx_overrun);
        end
        checks = checks + 1;
        if (done_count - d0 !== 2) begin
            failures = failures + 1;
            $display("FAIL ovr_done_count: %0d pulses expected 2", done_count - d0);
        end
        pulse_ack();
        checks = checks + 1;
        if (rx_if.rx_valid !== 1'b0 || rx_if.rx_overrun !== 1'b0) begin
            failures = failures + 1;
            $display("FAIL ovr_ack_clear: valid=%b overrun=%b expected 0 0", rx_if.rx_valid, rx_if.rx_overrun);
        end
        idle(4);
    endtask

    task automatic test_ack_collision();
        exp_q.push_back(8'h12);
        send_frame(8'h12, 1'b1, 1'b0);
        idle(4);
        exp_q.push_back(8'hC3);
        send_frame(8'hC3, 1'b1, 1'b1);
        idle(4);
        checks = checks + 1;
        if (rx_if.data_out !== 8'hC3 || rx_if.rx_valid !== 1'b1 || rx_if.rx_overrun !== 1'b0) begin
            failures = failures + 1;
            $display("FAIL collision: data_out=%h valid=%b overrun=%b expected c3 1 0",
                     rx_if.data_out, rx_if.rx_valid, rx_if.rx_overrun);
        end
        pulse_ack();
        idle(4);
    endtask

    task automatic test_reset_midframe();
        int e0;
        e0 = err_count;
        data_in_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        data_in_rx = 1'b1;
        repeat (4 * CPB + HALF) @(negedge clk);
        checks = checks + 1;
        if (rx_if.rx_ongoing !== 1'b1) begin
            failures = failures + 1;
            $display("FAIL rst_mid_ongoing: ongoing=%b expected 1 before reset", rx_if.rx_ongoing);
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checks = checks + 1;
        if ({rx_if.data_out, rx_if.rx_valid, rx_if.rx_ongoing, rx_if.rx_done,
             rx_if.rx_frame_err, rx_if.rx_overrun} !== 13'd0) begin
            failures = failures + 1;
            $display("FAIL rst_mid_outputs: data_out=%h valid=%b ongoing=%b done=%b err=%b ovr=%b, expected all 0",
                     rx_if.data_out, rx_if.rx_valid, rx_if.rx_ongoing, rx_if.rx_done,
                     rx_if.rx_frame_err, rx_if.rx_overrun);
        end
        idle(5 * CPB);
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1, 1'b0);
        idle(4);
        checks = checks + 1;
        if (rx_if.data_out !== 8'hA5 || rx_if.rx_valid !== 1'b1 || err_count !== e0) begin
            failures = failures + 1;
            $display("FAIL rst_mid_recover: data_out=%h valid=%b errs=%0d expected a5 1 0",
                     rx_if.data_out, rx_if.rx_valid, err_count - e0);
        end
    endtask

    initial begin
        rx_if.rx_ack = 1'b0;
        @(negedge clk);
        test_reset();
        test_loopback();
        test_glitch();
        test_frame_err();
        test_overrun();
        test_ack_collision();
        test_reset_midframe();
        idle(8);
        checks = checks + 1;
        if (exp_q.size() !== 0) begin
            failures = failures + 1;
            $display("FAIL sb_leftover: %0d expected bytes never delivered, expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
Serial-to-parallel UART receiver, the downstream partner of UART_Transmitter: consumes its serial line and recovers 8N1 frames (1 start, 8 data LSB-first, 1 stop). The line is synchronised, the start bit is validated at mid-bit, and each bit is sampled at its centre. Each good byte is presented with a valid/ack handshake, plus framing-error and overrun flags.

Parameters:
CLKS_PER_BIT, 16, clock cycles per bit period; must equal the transmitter's setting; legal range >= 4.
HALF_BIT, CLKS_PER_BIT/2 (derived localparam), offset from start edge to mid-bit.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  synchronous active-low reset
data_in_rx  input  1  asynchronous serial line, idle high
rx_ack  input  1  consumer accepts data_out; sampled only while rx_valid=1
data_out  output  8  last good received byte
rx_valid  output  1  data_out holds an unconsumed byte
rx_ongoing  output  1  frame in progress (START, DATA, STOP)
rx_done  output  1  one-cycle pulse per good frame
rx_frame_err  output  1  one-cycle pulse when the stop bit samples 0
rx_overrun  output  1  sticky: a good frame arrived while rx_valid=1

Behaviour:
- Reset (rst_n=0 at a clk edge): state IDLE; all counters 0; both synchroniser flops 1; all outputs 0, including data_out. Applies mid-frame; the partial frame is discarded.
- Synchroniser: 2 flops; the FSM sees only the second-stage value (sync_rx).
- Let T0 be the first edge at which data_in_rx=0.
- IDLE: when sync_rx=0 (edge T0+2), go to START with cnt=0.
- START: increment cnt; when cnt==HALF_BIT-1 (edge T0+2+HALF_BIT):
  - sync_rx=0: go to DATA with cnt=0, bit_idx=0.
  - otherwise: glitch; return to IDLE with no pulse.
- DATA: when cnt==CLKS_PER_BIT-1, shift sync_rx into shift_reg[bit_idx], reset cnt and increment bit_idx. After bit 7 is sampled, go to STOP.
  - Bit i (0..7) is sampled at edge T0+2+HALF_BIT+(i+1)*CLKS_PER_BIT.
- STOP: sample at cnt==CLKS_PER_BIT-1, i.e. edge Ts = T0+2+HALF_BIT+9*CLKS_PER_BIT.
  - Sample 1, good frame: rx_done=1 for the single cycle after Ts; go to IDLE.
  - Sample 0, framing error: rx_frame_err=1 for the single cycle after Ts; byte discarded; go to BREAK.
- BREAK: remain until sync_rx=1, then go to IDLE. A held-low line therefore never yields a phantom start.
- rx_ongoing=1 exactly while state is START, DATA or STOP.
- Handshake (evaluated at Ts on a good frame):
  - rx_valid=0: data_out<=shift_reg; rx_valid<=1.
  - rx_valid=1 and rx_ack=0: data_out is kept and the new byte is dropped; rx_overrun<=1. rx_done still pulses.
  - rx_valid=1 and rx_ack=1 in the same cycle: old byte is consumed, new byte loaded, rx_valid stays 1, no overrun.
  - Otherwise rx_ack with rx_valid=1 clears rx_valid and rx_overrun on the next edge.
  - rx_ack while rx_valid=0 is ignored.
- Latency with CLKS_PER_BIT=16: rx_done high in cycle T0+154..T0+155.
- Back-to-back frames: a start bit immediately after the stop bit is accepted. After a good frame the FSM is in IDLE before the next falling edge reaches sync_rx.

Decomposition:
- Shared package uart_pkg:
  - state encoding (IDLE, START, DATA, STOP, BREAK)
  - default CLKS_PER_BIT, also used by UART_Transmitter
  - DATA_BITS=8 constant
- One sub-module: uart_sync_2ff (two-flop synchroniser; reset value 1; synchronous active-low reset).

Test Plan:
1. Loopback from UART_Transmitter with data_in=8'b10110111, rx_ack=0:
   - data_out=8'hB7, rx_valid=1, rx_done pulse at T0+154, rx_frame_err=0.
2. Glitch: data_in_rx low for 4 cycles, then high:
   - rx_ongoing high for HALF_BIT cycles, then back to 0.
   - No rx_done, rx_frame_err or rx_valid.
3. Framing error: hand-driven frame 8'h55 with stop bit 0, line then held low 40 cycles, then high:
   - rx_frame_err pulses once; rx_valid stays 0.
   - No new frame starts until the line returns high.
   - A following 8'h3C is received correctly.
4. Overrun: frames 8'h12 then 8'h34, no ack:
   - data_out=8'h12, rx_overrun=1, two rx_done pulses.
   - Pulse rx_ack: next cycle rx_valid=0, rx_overrun=0.
5. Ack collision: hold rx_ack=1 during the cycle the second frame (8'hC3) completes while 8'h12 is pending:
   - data_out=8'hC3, rx_valid=1, rx_overrun=0.
6. Reset mid-frame: rst_n=0 for one cycle during data bit 4 of 8'hFF:
   - All outputs 0 the next cycle.
   - Subsequent frame 8'hA5 gives data_out=8'hA5 with no framing error.
